// File: rtl/matrix_vector_checker_pkg.sv
// Shared types and sizing helpers for the matrix/vector checker.
package matrix_pkg;

  typedef logic [7:0] elem_t;

  localparam int ROW_DEF = 4;
  localparam int COL_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Index width that stays legal (>=1 bit) for single-row or single-column shapes.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_vector_checker_if.sv
// Request/result bundle between an upstream driver (master) and the checker (slave).
interface matrix_vector_checker_if
  import matrix_pkg::*;
#(
  parameter int ROW    = ROW_DEF,
  parameter int COLUMN = COL_DEF
);
  localparam int EW = $clog2(ROW*COLUMN+1);
  localparam int RW = idx_w(ROW);
  localparam int CW = idx_w(COLUMN);

  elem_t [ROW-1:0][COLUMN-1:0] exp_mat;
  logic                        start;
  logic                        abort;
  logic                        vec_valid;
  elem_t                       vec_data;
  logic                        vec_ready;
  logic                        busy;
  logic                        done;
  logic                        pass;
  logic [EW-1:0]               err_count;
  logic                        first_err_valid;
  logic [RW-1:0]               first_err_row;
  logic [CW-1:0]               first_err_col;

  modport master (
    output exp_mat, start, abort, vec_valid, vec_data,
    input  vec_ready, busy, done, pass, err_count,
           first_err_valid, first_err_row, first_err_col
  );

  modport slave (
    input  exp_mat, start, abort, vec_valid, vec_data,
    output vec_ready, busy, done, pass, err_count,
           first_err_valid, first_err_row, first_err_col
  );
endinterface

// File: rtl/matrix_vector_checker.sv
// Streams a row-major test vector against a snapshot of the expected matrix,
// counting mismatches and latching the position of the first one.
module matrix_vector_checker
  import matrix_pkg::*;
#(
  parameter int ROW    = ROW_DEF,
  parameter int COLUMN = COL_DEF
)(
  input  logic                    clk,
  input  logic                    rst,
  matrix_vector_checker_if.slave  bus
);
  localparam int EW = $clog2(ROW*COLUMN+1);
  localparam int RW = idx_w(ROW);
  localparam int CW = idx_w(COLUMN);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW-1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLUMN-1);

  state_t                      state_q;
  elem_t [ROW-1:0][COLUMN-1:0] snap_q;
  logic [RW-1:0]               row_q;
  logic [CW-1:0]               col_q;
  logic [EW-1:0]               err_q, err_d;
  logic                        done_q, pass_q, busy_q, fev_q;
  logic [RW-1:0]               fer_q;
  logic [CW-1:0]               fec_q;

  logic accept, mismatch, last;

  // Abort wins over a same-cycle element, so ready drops with abort.
  assign bus.vec_ready = (state_q == S_RUN) && !bus.abort;
  assign accept        = bus.vec_valid && bus.vec_ready;
  assign mismatch      = bus.vec_data != snap_q[row_q][col_q];
  assign last          = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign err_d         = err_q + EW'(mismatch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      fev_q   <= 1'b0;
      fer_q   <= '0;
      fec_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start) begin
          state_q <= S_RUN;
          busy_q  <= 1'b1;
          snap_q  <= bus.exp_mat;
          row_q   <= '0;
          col_q   <= '0;
          err_q   <= '0;
          pass_q  <= 1'b0;
          fev_q   <= 1'b0;
          fer_q   <= '0;
          fec_q   <= '0;
        end
        S_RUN: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (accept) begin
            err_q <= err_d;
            if (mismatch && !fev_q) begin
              fev_q <= 1'b1;
              fer_q <= row_q;
              fec_q <= col_q;
            end
            if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
            // Verdict uses err_d so the final element's own mismatch counts.
            if (last) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_row   = fer_q;
  assign bus.first_err_col   = fec_q;

endmodule

// File: tb/tb_matrix_vector_checker.sv
// Scoreboard bench: each pass pushes its expected verdict; a monitor pops on done.
module tb_matrix_vector_checker;
  import matrix_pkg::*;

  typedef struct {
    int lat;
    int err;
    int pass;
    int fev;
    int row;
    int col;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_vector_checker_if #(.ROW(4), .COLUMN(4)) bus ();

  matrix_vector_checker #(.ROW(4), .COLUMN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_chk  = 0;
  int    n_pass = 0;
  int    cyc    = 0;
  int    start_cyc = 0;
  exp_t  q[$];
  exp_t  e;
  elem_t mat    [16];
  elem_t stream [16];

  function automatic void chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("done_latency", cyc - start_cyc + 1, e.lat);
        chk("err_count",    int'(bus.err_count), e.err);
        chk("pass",         int'(bus.pass), e.pass);
        chk("first_valid",  int'(bus.first_err_valid), e.fev);
        chk("first_row",    int'(bus.first_err_row), e.row);
        chk("first_col",    int'(bus.first_err_col), e.col);
        chk("busy_in_done", int'(bus.busy), 0);
      end
    end
  end

  task automatic load_mat();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        bus.exp_mat[r][c] = mat[r*4+c];
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, int'(bus.vec_ready), 0);
    chk({tag, "_busy"},  int'(bus.busy), 0);
    chk({tag, "_done"},  int'(bus.done), 0);
    chk({tag, "_pass"},  int'(bus.pass), 0);
    chk({tag, "_err"},   int'(bus.err_count), 0);
    chk({tag, "_fev"},   int'(bus.first_err_valid), 0);
    chk({tag, "_frow"},  int'(bus.first_err_row), 0);
    chk({tag, "_fcol"},  int'(bus.first_err_col), 0);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 40 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      chk({tag, "_done_timeout"}, q.size(), 0);
      q.delete();
    end
  endtask

  task automatic run_pass(input bit toggle, input int abort_at, input int rst_at,
                          input bit mutate, input bit start_in_done);
    int idx;
    int n;
    bit acc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.vec_valid = 1'b0;
    @(posedge clk);
    #1 start_cyc = cyc;
    idx = 0;
    n   = 0;
    while (idx < 16 && n < 100) begin
      @(negedge clk);
      bus.start     = 1'b0;
      bus.vec_valid = toggle ? (n % 2 == 0) : 1'b1;
      bus.vec_data  = stream[idx];
      if (mutate && idx == 3) bus.exp_mat[0][0] = 8'hFF;
      if (idx == abort_at) begin
        bus.abort = 1'b1;
        #1 chk("ready_in_abort", int'(bus.vec_ready), 0);
        @(posedge clk);
        #1;
        bus.abort     = 1'b0;
        bus.vec_valid = 1'b0;
        chk("abort_busy",  int'(bus.busy), 0);
        chk("abort_ready", int'(bus.vec_ready), 0);
        chk("abort_pass",  int'(bus.pass), 0);
        chk("abort_err",   int'(bus.err_count), 2);
        chk("abort_fev",   int'(bus.first_err_valid), 1);
        chk("abort_frow",  int'(bus.first_err_row), 0);
        chk("abort_fcol",  int'(bus.first_err_col), 1);
        return;
      end
      if (idx == rst_at) begin
        rst = 1'b1;
        #1 check_reset("rst_mid");
        bus.vec_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      #1 acc = bus.vec_valid && bus.vec_ready;
      @(posedge clk);
      if (acc) idx++;
      n++;
    end
    chk("stream_accepts", idx, 16);
    @(negedge clk);
    bus.vec_valid = 1'b0;
    if (mutate) load_mat();
    if (start_in_done) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("start_in_done_busy", int'(bus.busy), 0);
      @(negedge clk);
      chk("start_in_done_busy2", int'(bus.busy), 0);
      chk("start_in_done_ready", int'(bus.vec_ready), 0);
    end
  endtask

  initial begin
    mat = '{8'd0, 8'd0, 8'd1, 8'd1,
            8'd1, 8'd2, 8'd3, 8'd1,
            8'd2, 8'd1, 8'd2, 8'd1,
            8'd1, 8'd2, 8'd3, 8'd1};
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.vec_valid = 1'b0;
    bus.vec_data  = '0;
    load_mat();
    #1 check_reset("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // clean match, every cycle valid
    stream = mat;
    q.push_back('{17, 0, 1, 0, 0, 0});
    run_pass(1'b0, -1, -1, 1'b0, 1'b0);
    wait_drain("match");

    // two mismatches: (1,2) and (3,0)
    stream = mat;
    stream[6]  = 8'h7;
    stream[12] = 8'h0;
    q.push_back('{17, 2, 0, 1, 1, 2});
    run_pass(1'b0, -1, -1, 1'b0, 1'b0);
    wait_drain("mismatch");
    repeat (3) @(negedge clk);
    chk("hold_err",  int'(bus.err_count), 2);
    chk("hold_frow", int'(bus.first_err_row), 1);

    // back-pressure: valid toggles every cycle
    stream = mat;
    q.push_back('{32, 0, 1, 0, 0, 0});
    run_pass(1'b1, -1, -1, 1'b0, 1'b0);
    wait_drain("backpressure");

    // abort after 5 accepts carrying mismatches at (0,1) and (1,0)
    stream = mat;
    stream[1] = 8'h9;
    stream[4] = 8'h9;
    run_pass(1'b0, 5, -1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("post_abort_err", int'(bus.err_count), 2);

    // exp_mat changes mid-run must not matter
    stream = mat;
    q.push_back('{17, 0, 1, 0, 0, 0});
    run_pass(1'b0, -1, -1, 1'b1, 1'b0);
    wait_drain("snapshot");

    // reset mid-run, then no done afterwards
    stream = mat;
    stream[0] = 8'h5;
    run_pass(1'b0, -1, 6, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check_reset("post_rst");

    // start during DONE ignored, then a fresh pass from IDLE
    stream = mat;
    q.push_back('{17, 0, 1, 0, 0, 0});
    run_pass(1'b0, -1, -1, 1'b0, 1'b1);
    wait_drain("done_start");
    stream = mat;
    stream[6]  = 8'h7;
    stream[12] = 8'h0;
    q.push_back('{17, 2, 0, 1, 1, 2});
    run_pass(1'b0, -1, -1, 1'b0, 1'b0);
    wait_drain("fresh");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/matrix_vector_checker.md
MATRIX_VECTOR_CHECKER -- requirements
Module: matrix_vector_checker

Interface
REQ-001 Parameter ROW, default 4, number of matrix rows.
REQ-002 Parameter COLUMN, default 4, number of matrix columns.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 exp_mat  input  8 x [ROW][COLUMN]  expected matrix, driven by upstream matrix_module.
REQ-006 start  input  1  request to begin one check pass.
REQ-007 abort  input  1  cancel a pass in progress.
REQ-008 vec_valid  input  1  test-vector element available.
REQ-009 vec_data  input  8  test-vector element, row-major order.
REQ-010 vec_ready  output  1  checker accepts an element this cycle.
REQ-011 busy  output  1  pass in progress.
REQ-012 done  output  1  one-cycle pulse at end of a completed pass.
REQ-013 pass  output  1  last completed pass had zero mismatches.
REQ-014 err_count  output  clog2(ROW*COLUMN+1)  mismatch count of current or last pass.
REQ-015 first_err_valid, first_err_row, first_err_col  output  1, clog2(ROW), clog2(COLUMN)  position of the first mismatch.

Function
REQ-016 FSM states: IDLE, RUN, DONE.
REQ-017 IDLE->RUN on start=1.
- Snapshot exp_mat into an internal register array.
- Clear err_count, pass and first_err_*.
- Zero the row and column counters.
REQ-018 Element handshake: accepted when vec_valid=1 and vec_ready=1; vec_ready=1 only in RUN, combinationally from state.
REQ-019 Comparison: each accepted element is compared with snapshot[row][col], never with the live exp_mat; changes on exp_mat during RUN have no effect.
REQ-020 Mismatch: err_count increments by 1, registered in the accept cycle.
- The first mismatch of a pass sets first_err_valid=1 and latches row/col.
- Later mismatches leave first_err_* unchanged.
REQ-021 Counters: col increments per accept; at col=COLUMN-1, col wraps to 0 and row increments.
REQ-022 Last element: accept at row=ROW-1, col=COLUMN-1 moves RUN->DONE.
REQ-023 DONE lasts exactly one cycle.
- done=1.
- pass=1 if final err_count=0.
- Then returns to IDLE.
- done is asserted the cycle after the final handshake.
REQ-024 Result hold: err_count, pass and first_err_* hold their values in IDLE until the next accepted start.
REQ-025 busy=1 in RUN, 0 in IDLE and DONE.
REQ-026 start is ignored in RUN and DONE.
REQ-027 abort=1 in RUN returns to IDLE next cycle.
- No done pulse; pass=0.
- err_count and first_err_* keep partial values.
- An element presented in the abort cycle is not accepted (vec_ready=0 when abort=1).
REQ-028 abort is ignored in IDLE and DONE.
REQ-029 Arithmetic: err_count is unsigned and cannot overflow (maximum ROW*COLUMN).
REQ-030 vec_valid=0 cycles in RUN stall the counters with no state change.

Reset
REQ-031 rst=1 asynchronously forces:
- state=IDLE;
- vec_ready=0, busy=0, done=0, pass=0;
- err_count=0;
- first_err_valid=0, first_err_row=0, first_err_col=0;
- counters=0 and snapshot=0.
REQ-032 rst asserted mid-RUN discards the pass; no done pulse follows deassertion.

Structure
REQ-033 Shared package matrix_pkg holds:
- elem_t (8-bit element typedef);
- default ROW/COLUMN constants;
- the state enum type.
REQ-034 No sub-module is required; the comparator and counters are inline.

Verification
REQ-035 Match: exp_mat rows {0,0,1,1},{1,2,3,1},{2,1,2,1},{1,2,3,1}; stream the identical 16 values with valid always 1.
- Expected: done on cycle 17 after start, pass=1, err_count=0, first_err_valid=0.
REQ-036 Mismatches: same matrix; element (1,2) sent as 8'h7 and (3,0) sent as 8'h0.
- Expected: err_count=2, pass=0, first_err_row=1, first_err_col=2.
REQ-037 Back-pressure: vec_valid toggled 1/0 every cycle.
- Expected: 16 accepts, done 32 cycles after start, results as in REQ-035.
REQ-038 Abort: abort after 5 accepts.
- Expected: IDLE next cycle, no done pulse, busy=0, err_count reflects the 5 elements.
REQ-039 Snapshot: change exp_mat[0][0] to 8'hFF mid-RUN; stream the original values.
- Expected: pass=1.
REQ-040 Reset and start: assert rst mid-RUN.
- Expected: all outputs at REQ-031 values immediately.
- A start pulse during DONE is ignored; a second start in IDLE runs a fresh pass.
